int_fp_acc: RTL and testbench
=============================

# int_fp_acc

Dot-product accumulator sitting directly downstream of the shared int/fp16 multiplier in each systolic-array PE. It consumes one 16-bit product per cycle over a valid/ready handshake and sums a programmed number of products. Int mode sums into a wide two's-complement register; fp16 mode sums into an fp16 register. It then presents the result and a sticky error flag on an output handshake.

## Interface
Parameters:
- ACC_W, 20: int accumulator width; legal range 16..32.
- CNT_W, 8: width of the beat-count input `len`.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  begin a new dot product; sampled only in IDLE.
- mode  in  1  1 = fp16, 0 = int; latched on the accepted `start`.
- len  in  CNT_W  number of products to sum; latched on the accepted `start`.
- in_valid  in  1  product beat valid.
- in_ready  out  1  accumulator accepts a beat.
- prod  in  16  multiplier result; int mode = two's complement, fp16 mode = IEEE half.
- prod_err  in  1  multiplier error flag that accompanies `prod`.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- acc_out  out  ACC_W  result. Int: full width. Fp16: [15:0], upper bits 0.
- acc_err  out  1  sticky error for the current dot product.

## Operation
- FSM states: IDLE, ACCUM, DONE. Encoding lives in the package.
- IDLE:
  - Accepted `start` clears acc, acc_err and the counter, and latches mode and len.
  - len == 0 goes to DONE with acc = 0; otherwise goes to ACCUM.
- ACCUM:
  - in_ready = 1.
  - Each beat (in_valid & in_ready) adds `prod` into acc and decrements the remaining count.
  - The beat that takes the count to 0 moves the FSM to DONE.
  - in_valid low stalls the FSM in ACCUM with no state change.
- DONE:
  - out_valid = 1; acc_out and acc_err are held stable.
  - out_valid & out_ready moves the FSM to IDLE.
- `start` outside IDLE is ignored. `mode` and `len` changes outside the accepted start are ignored.
- Int arithmetic:
  - `prod` is sign-extended to ACC_W and added.
  - Overflow handling is governed by the Configuration section.
  - prod_err is ignored in int mode.
- Fp16 arithmetic, performed by the fp16_add sub-module:
  - Rounds toward zero; subnormal inputs and results flush to signed zero.
  - Exponent 31 is treated as inf. Once acc is inf it stays unchanged.
  - Overflow produces signed inf (0x7C00 or 0xFC00) and sets acc_err.
  - prod_err = 1 on an accepted beat sets acc_err.
- acc_err is sticky from start until the result handshake completes.

## Timing
- Reset values: in_ready = 0, out_valid = 0, acc_out = 0, acc_err = 0, FSM = IDLE.
- Reset is honoured mid-operation: asynchronous return to IDLE with all outputs at reset values. A partial sum is discarded.
- start → in_ready = 1 on the next cycle.
- Throughput is one beat per cycle with no bubbles.
- Last accepted beat → out_valid = 1 on the next cycle, with the final sum already on acc_out.
- acc_out is a registered value and updates one cycle after each beat.
- out_valid falls the cycle after the result handshake. A new start is accepted in the cycle after that, once the FSM is in IDLE.
- The minimum period of a len = N operation is N + 2 cycles between starts with out_ready tied high.

## Configuration
- INT_FP_ACC_SAT_EN defined:
  - Int adds saturate to +2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - The first saturating beat sets acc_err.
- Macro undefined:
  - Int adds wrap modulo 2^ACC_W.
  - acc_err is never set in int mode.
- Fp16 behaviour is identical with or without the macro.

## Structure
- Shared package int_fp_pkg holds:
  - FSM state typedef: IDLE, ACCUM, DONE.
  - FP16 constants: EXP_W = 5, MAN_W = 10, BIAS = 15, FP16_INF = 16'h7C00, FP16_EXP_MAX = 5'h1F.
- Sub-module fp16_add: combinational fp16 + fp16 → fp16 plus an overflow flag.
  - Performs align, add/subtract, normalize and truncate.
  - Instantiated once; its output is registered in int_fp_acc.

## Test plan
- Int, len = 3, prods 0x0005, 0xFFFD, 0x0064 → out_valid one cycle after the third beat; acc_out = 0x00066; acc_err = 0.
- Fp16, len = 2, prods 0x3C00, 0x3C00 → acc_out = 0x4000; len = 2, prods 0x7BFF, 0x7BFF → acc_out = 0x7C00, acc_err = 1.
- Int with INT_FP_ACC_SAT_EN and ACC_W = 20, 17 beats of 0x7FFF → acc_out = 0x7FFFF, acc_err = 1. Without the macro → acc_out = 0x87FEF, acc_err = 0.
- len = 0 start → out_valid the next cycle, acc_out = 0; in_ready never asserted.
- In DONE with out_ready low for 5 cycles and start pulsed → out_valid and acc_out held, start ignored. out_ready high → IDLE the following cycle.
- rst_n low after 2 of 4 beats → outputs at reset values immediately. New start with len = 1, prod 0x0007 → acc_out = 0x00007.

Source files
------------

// File: rtl/int_fp_pkg.sv
// Shared types and fp16 constants for the int/fp16 dot-product accumulator.
package int_fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          EXP_W        = 5;
  localparam int          MAN_W        = 10;
  localparam int          BIAS         = 15;
  localparam logic [15:0] FP16_INF     = 16'h7C00;
  localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

endpackage

// File: rtl/fp16_add.sv
// Combinational fp16 + fp16 -> fp16 adder, round toward zero.
// Subnormal inputs/results flush to signed zero; exponent 31 means inf.
// ovf flags a finite sum whose exponent ran past the largest normal.
module fp16_add
  import int_fp_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        ovf
);

  logic        sa, sb, sl, ss;
  logic [4:0]  ea, eb, el, es, diff;
  logic [9:0]  fa, fb, man;
  logic [10:0] ml, ms;
  logic [13:0] full, shifted, aligned;
  logic        sticky, a_zero, b_zero, a_inf, b_inf, swap, subtract;
  logic [14:0] lw, raw;
  logic [3:0]  lz;
  logic [6:0]  exp_n;

  // Index of the leading one counted from bit 13; 14 when the value is zero.
  function automatic logic [3:0] lzc14(input logic [13:0] v);
    logic [3:0] r;
    r = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (v[i]) r = 4'(13 - i);
    end
    return r;
  endfunction

  // Align the smaller operand, add or subtract magnitudes, normalize, truncate.
  always_comb begin
    sa = a[15]; ea = a[14:10]; fa = a[9:0];
    sb = b[15]; eb = b[14:10]; fb = b[9:0];
    a_zero = (ea == 5'd0);
    b_zero = (eb == 5'd0);
    a_inf  = (ea == FP16_EXP_MAX);
    b_inf  = (eb == FP16_EXP_MAX);

    swap = ({eb, fb} > {ea, fa});
    sl = swap ? sb : sa;
    el = swap ? eb : ea;
    ml = swap ? {1'b1, fb} : {1'b1, fa};
    ss = swap ? sa : sb;
    es = swap ? ea : eb;
    ms = swap ? {1'b1, fa} : {1'b1, fb};
    diff = el - es;

    // Three extension bits below the mantissa; bit 0 collects a sticky OR so
    // truncation after subtraction stays exact.
    full = {ms, 3'b000};
    if (diff >= 5'd14) begin
      shifted = 14'd0;
      sticky  = 1'b1;
    end else begin
      shifted = full >> diff;
      sticky  = |(full & ~({14{1'b1}} << diff));
    end
    aligned = {shifted[13:1], shifted[0] | sticky};

    subtract = sl ^ ss;
    lw  = {1'b0, ml, 3'b000};
    raw = subtract ? (lw - {1'b0, aligned}) : (lw + {1'b0, aligned});

    lz = lzc14(raw[13:0]);
    if (raw[14]) begin
      man   = raw[13:4];
      exp_n = {2'b00, el} + 7'd1;
    end else begin
      man   = 10'((raw[13:0] << lz) >> 3);
      exp_n = {2'b00, el} - {3'b000, lz};
    end

    sum = 16'h0000;
    ovf = 1'b0;
    if (a_inf || b_inf) begin
      sum = a_inf ? {sa, FP16_INF[14:0]} : {sb, FP16_INF[14:0]};
    end else if (a_zero && b_zero) begin
      sum = {sa & sb, 15'd0};
    end else if (a_zero) begin
      sum = b;
    end else if (b_zero) begin
      sum = a;
    end else if (raw == 15'd0) begin
      sum = 16'h0000;
    end else if (exp_n[6] || exp_n == 7'd0) begin
      sum = {sl, 15'd0};
    end else if (exp_n >= 7'd31) begin
      sum = {sl, FP16_INF[14:0]};
      ovf = 1'b1;
    end else begin
      sum = {sl, exp_n[4:0], man};
    end
  end

endmodule

// File: rtl/int_fp_acc.sv
// Dot-product accumulator behind the PE multiplier: sums len products in
// int (wide two's complement) or fp16 mode and hands the result out on a
// valid/ready port with a sticky error flag.
// Optional feature: define INT_FP_ACC_SAT_EN to saturate int sums (and flag
// the saturation in acc_err); otherwise int sums wrap silently.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and ready/valid here are pure
// functions of the registered FSM state.
module int_fp_acc
  import int_fp_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      prod,
  input  logic             prod_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_err
);

  state_t             state, state_nxt;
  logic               mode_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [ACC_W-1:0]   acc_r;
  logic               err_r;
  logic               start_ok, beat, done_hs;
  logic [ACC_W-1:0]   prod_ext, int_sum, int_next;
  logic               int_err;
  logic [15:0]        fp_sum;
  logic               fp_ovf, acc_inf;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign acc_out   = acc_r;
  assign acc_err   = err_r;
  assign start_ok  = (state == IDLE) && start;
  assign beat      = in_valid && in_ready;
  assign done_hs   = out_valid && out_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: the beat that drains the count ends the accumulation.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : ACCUM;
      ACCUM:   if (in_valid && cnt_r == CNT_W'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Int path: sign-extend the product, then wrap or saturate.
  always_comb begin
    prod_ext = ACC_W'($signed(prod));
    int_sum  = acc_r + prod_ext;
`ifdef INT_FP_ACC_SAT_EN
    if ((acc_r[ACC_W-1] == prod_ext[ACC_W-1]) && (int_sum[ACC_W-1] != acc_r[ACC_W-1])) begin
      int_next = acc_r[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      int_err  = 1'b1;
    end else begin
      int_next = int_sum;
      int_err  = 1'b0;
    end
`else
    int_next = int_sum;
    int_err  = 1'b0;
`endif
  end

  fp16_add u_fp16_add (
    .a   (acc_r[15:0]),
    .b   (prod),
    .sum (fp_sum),
    .ovf (fp_ovf)
  );

  assign acc_inf = (acc_r[14:10] == FP16_EXP_MAX);

  // Datapath registers: clear on start, accumulate per beat, drop the error
  // once the result has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= 1'b0;
      cnt_r  <= '0;
      acc_r  <= '0;
      err_r  <= 1'b0;
    end else if (start_ok) begin
      mode_r <= mode;
      cnt_r  <= len;
      acc_r  <= '0;
      err_r  <= 1'b0;
    end else if (beat) begin
      cnt_r <= cnt_r - CNT_W'(1);
      if (mode_r) begin
        if (!acc_inf) acc_r <= ACC_W'(fp_sum);
        err_r <= err_r | prod_err | (fp_ovf & ~acc_inf);
      end else begin
        acc_r <= int_next;
        err_r <= err_r | int_err;
      end
    end else if (done_hs) begin
      err_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_int_fp_acc.sv
// Directed self-checking bench for int_fp_acc (ACC_W = 20, CNT_W = 8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_int_fp_acc;
  localparam int ACC_W = 20;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             mode;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      prod;
  logic             prod_err;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             acc_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ACC_W-1:0] exp_q[$];
  logic [15:0]      beat_q[$];
  logic             err_q[$];

  int_fp_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .prod_err  (prod_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .acc_err   (acc_err)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d)", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic add_beat(input logic [15:0] p, input logic e);
    beat_q.push_back(p);
    err_q.push_back(e);
  endtask

  task automatic start_op(input logic m, input logic [CNT_W-1:0] l);
    start = 1'b1;
    mode  = m;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    mode  = $urandom_range(0, 1);
    len   = CNT_W'($urandom_range(0, 255));
  endtask

  // Full transaction: start, queued beats back to back, result checks, handshake.
  task automatic run_op(input string tag, input logic m, input logic [CNT_W-1:0] l,
                        input logic [ACC_W-1:0] exp_acc, input logic exp_err);
    exp_q.push_back(exp_acc);
    start_op(m, l);
    check({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, l != '0});
    foreach (beat_q[i]) begin
      in_valid = 1'b1;
      prod     = beat_q[i];
      prod_err = err_q[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    prod_err = 1'b0;
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, " acc_out"}, 32'(acc_out), 32'(exp_q.pop_front()));
    check({tag, " acc_err"}, {31'd0, acc_err}, {31'd0, exp_err});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid low"}, {31'd0, out_valid}, 32'd0);
    beat_q.delete();
    err_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; len = '0;
    in_valid = 1'b0; prod = '0; prod_err = 1'b0; out_ready = 1'b0;
    #1;
    check("rst in_ready",  {31'd0, in_ready},  32'd0);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst acc_out",   32'(acc_out),       32'd0);
    check("rst acc_err",   {31'd0, acc_err},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Int: 5 - 3 + 100 = 102.
    add_beat(16'h0005, 1'b0); add_beat(16'hFFFD, 1'b1); add_beat(16'h0064, 1'b0);
    run_op("int3", 1'b0, 8'd3, 20'h00066, 1'b0);

    // Fp16: 1.0 + 1.0 = 2.0.
    add_beat(16'h3C00, 1'b0); add_beat(16'h3C00, 1'b0);
    run_op("fp_one", 1'b1, 8'd2, 20'h04000, 1'b0);

    // Fp16: max normal doubled overflows to +inf.
    add_beat(16'h7BFF, 1'b0); add_beat(16'h7BFF, 1'b0);
    run_op("fp_ovf", 1'b1, 8'd2, 20'h07C00, 1'b1);

    // Fp16: 2.0 + (-1.0) = 1.0 (subtract path with renormalize).
    add_beat(16'h4000, 1'b0); add_beat(16'hBC00, 1'b0);
    run_op("fp_sub", 1'b1, 8'd2, 20'h03C00, 1'b0);

    // Fp16: multiplier error flag is sticky into acc_err.
    add_beat(16'h3C00, 1'b1); add_beat(16'h3C00, 1'b0);
    run_op("fp_perr", 1'b1, 8'd2, 20'h04000, 1'b1);

    // Fp16: once inf, further beats leave acc unchanged.
    add_beat(16'hFC00, 1'b0); add_beat(16'h3C00, 1'b0);
    run_op("fp_inf", 1'b1, 8'd2, 20'h0FC00, 1'b0);

    // Int: 17 x 0x7FFF = 0x87FEF, beyond +2^19-1.
    for (int i = 0; i < 17; i++) add_beat(16'h7FFF, 1'b0);
`ifdef INT_FP_ACC_SAT_EN
    run_op("int_big", 1'b0, 8'd17, 20'h7FFFF, 1'b1);
`else
    run_op("int_big", 1'b0, 8'd17, 20'h87FEF, 1'b0);
`endif

    // len = 0 goes straight to DONE with a zero result.
    run_op("len0", 1'b0, 8'd0, 20'h00000, 1'b0);

    // DONE holds the result while out_ready is low; start is ignored.
    start_op(1'b0, 8'd1);
    in_valid = 1'b1; prod = 16'h0009;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 1 || i == 2);
      mode  = 1'b1;
      len   = 8'd3;
      @(negedge clk);
      check("hold out_valid", {31'd0, out_valid}, 32'd1);
      check("hold acc_out",   32'(acc_out),       32'd9);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold released",    {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("hold start ignored", {31'd0, in_ready}, 32'd0);

    // Reset mid-operation discards the partial sum.
    start_op(1'b0, 8'd4);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; prod = 16'h0010;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre-rst acc_out", 32'(acc_out), 32'h20);
    rst_n = 1'b0;
    #1;
    check("midrst in_ready",  {31'd0, in_ready},  32'd0);
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst acc_out",   32'(acc_out),       32'd0);
    check("midrst acc_err",   {31'd0, acc_err},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    add_beat(16'h0007, 1'b0);
    run_op("post_rst", 1'b0, 8'd1, 20'h00007, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
